// File: rtl/usb_tx_pkg.sv
// -----------------------------------------------------------------------------
// usb_tx_pkg
// Shared types and constants for the USB TX arbiter slice.
//   tx_pkt_t     : engine command codes driven on tx_packet
//   arb_state_t  : arbiter FSM states
//   MAX_RETRY    : start-timeout reissues allowed when TX_RETRY_EN is defined
//   cnt_width()  : width of the shared timeout/gap down-counter
// -----------------------------------------------------------------------------
package usb_tx_pkg;

  typedef enum logic [1:0] {
    PKT_NONE = 2'b00,
    PKT_DATA = 2'b01,
    PKT_ACK  = 2'b10,
    PKT_NAK  = 2'b11
  } tx_pkt_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_START,
    ST_WAIT_END,
    ST_GAP
  } arb_state_t;

  localparam int MAX_RETRY = 3;

  // Wide enough to hold the larger of the two cycle limits.
  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/usb_tx_gap_timer.sv
// -----------------------------------------------------------------------------
// usb_tx_gap_timer
// Loadable down-counter with a zero flag. One instance serves both the
// start-timeout in WAIT_START and the inter-packet gap in GAP, since the
// arbiter is never in both states at once.
// Ports:
//   clk, n_rst : clock, asynchronous active-low reset
//   load       : load load_val (has priority over en)
//   en         : decrement by one, saturating at zero
//   load_val   : value to load
//   zero       : count is zero
// -----------------------------------------------------------------------------
module usb_tx_gap_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_q;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/usb_tx_arbiter.sv
// -----------------------------------------------------------------------------
// usb_tx_arbiter
// Shares the USB TX packet engine between the handshake responder (ACK/NAK)
// and the host data path (DATA). Grants one requester at a time, issues a
// one-cycle command, follows engine busy/done, then holds an inter-packet gap.
// Handshake has strict priority. All outputs are registered.
// Ports:
//   clk, n_rst          : clock, asynchronous active-low reset
//   hs_req/hs_type      : handshake request (level) and 0=ACK/1=NAK
//   hs_grant            : one-cycle grant to the handshake requester
//   data_req/data_size  : DATA request (level) and payload bytes
//   data_grant          : one-cycle grant to the data requester
//   buffer_occupancy    : bytes in the TX buffer, gates data eligibility
//   tx_busy             : engine active
//   tx_packet           : command 00 none / 01 DATA / 10 ACK / 11 NAK
//   tx_packet_data_size : DATA payload size, held until the next issue
//   tx_done / tx_error  : packet finished / engine never started
//   arb_busy            : high whenever not IDLE
// Build option: TX_RETRY_EN -- reissue the same command on start timeout, up
// to MAX_RETRY times, before reporting tx_error.
// -----------------------------------------------------------------------------
module usb_tx_arbiter
  import usb_tx_pkg::*;
#(
  parameter int GAP_CYCLES    = 16,
  parameter int START_TIMEOUT = 64,
  parameter int BUF_DEPTH     = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       hs_req,
  input  logic       hs_type,
  output logic       hs_grant,
  input  logic       data_req,
  input  logic [6:0] data_size,
  output logic       data_grant,
  input  logic [6:0] buffer_occupancy,
  input  logic       tx_busy,
  output logic [1:0] tx_packet,
  output logic [6:0] tx_packet_data_size,
  output logic       tx_done,
  output logic       tx_error,
  output logic       arb_busy
);

  localparam int CNT_W = cnt_width(GAP_CYCLES, START_TIMEOUT);
  // WAIT_START spans START_TIMEOUT-1 cycles so tx_error lands exactly
  // START_TIMEOUT cycles after the ISSUE cycle.
  localparam logic [CNT_W-1:0] START_LOAD = CNT_W'(START_TIMEOUT - 2);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

  arb_state_t       state_q, state_d;
  tx_pkt_t          cmd_q, cmd_d, pkt_d;
  logic [6:0]       size_d;
  logic             hs_grant_d, data_grant_d, done_d, error_d;
  logic             busy_early_q;
  logic             tmr_load, tmr_en, tmr_zero;
  logic [CNT_W-1:0] tmr_val;
  logic             data_ok;
`ifdef TX_RETRY_EN
  logic [1:0]       retry_q, retry_d;
`endif

  // Zero-length packets pass the occupancy test trivially; oversize never do.
  assign data_ok = data_req && (data_size <= 7'(BUF_DEPTH))
                && (buffer_occupancy >= data_size);

  usb_tx_gap_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    pkt_d        = PKT_NONE;
    size_d       = tx_packet_data_size;
    hs_grant_d   = 1'b0;
    data_grant_d = 1'b0;
    done_d       = 1'b0;
    error_d      = 1'b0;
    tmr_load     = 1'b0;
    tmr_en       = 1'b0;
    tmr_val      = '0;
`ifdef TX_RETRY_EN
    retry_d      = retry_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (hs_req) begin
          state_d    = ST_ISSUE;
          hs_grant_d = 1'b1;
          cmd_d      = hs_type ? PKT_NAK : PKT_ACK;
          pkt_d      = cmd_d;
          size_d     = '0;
`ifdef TX_RETRY_EN
          retry_d    = '0;
`endif
        end else if (data_ok) begin
          state_d      = ST_ISSUE;
          data_grant_d = 1'b1;
          cmd_d        = PKT_DATA;
          pkt_d        = PKT_DATA;
          size_d       = data_size;
`ifdef TX_RETRY_EN
          retry_d      = '0;
`endif
        end
      end
      ST_ISSUE: begin
        state_d  = ST_WAIT_START;
        tmr_load = 1'b1;
        tmr_val  = START_LOAD;
      end
      ST_WAIT_START: begin
        // Busy seen during ISSUE counts as the rise even if it has since fallen.
        if (tx_busy || busy_early_q) begin
          state_d = ST_WAIT_END;
        end else if (tmr_zero) begin
`ifdef TX_RETRY_EN
          if (retry_q < 2'(MAX_RETRY)) begin
            retry_d = retry_q + 2'd1;
            state_d = ST_ISSUE;
            pkt_d   = cmd_q;
          end else begin
            error_d = 1'b1;
            state_d = ST_IDLE;
          end
`else
          error_d = 1'b1;
          state_d = ST_IDLE;
`endif
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_WAIT_END: begin
        if (!tx_busy) begin
          done_d   = 1'b1;
          state_d  = ST_GAP;
          tmr_load = 1'b1;
          tmr_val  = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (tmr_zero) state_d = ST_IDLE;
        else          tmr_en  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q             <= ST_IDLE;
      cmd_q               <= PKT_NONE;
      busy_early_q        <= 1'b0;
      hs_grant            <= 1'b0;
      data_grant          <= 1'b0;
      tx_packet           <= PKT_NONE;
      tx_packet_data_size <= '0;
      tx_done             <= 1'b0;
      tx_error            <= 1'b0;
      arb_busy            <= 1'b0;
    end else begin
      state_q             <= state_d;
      cmd_q               <= cmd_d;
      busy_early_q        <= (state_q == ST_ISSUE) && tx_busy;
      hs_grant            <= hs_grant_d;
      data_grant          <= data_grant_d;
      tx_packet           <= pkt_d;
      tx_packet_data_size <= size_d;
      tx_done             <= done_d;
      tx_error            <= error_d;
      arb_busy            <= (state_d != ST_IDLE);
    end
  end

`ifdef TX_RETRY_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) retry_q <= '0;
    else        retry_q <= retry_d;
  end
`endif

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_usb_tx_arbiter
// Self-checking bench for usb_tx_arbiter. A timestamp-based reference model
// predicts every registered output each cycle; directed scenarios measure
// grant latency, gap length, timeout distance and reset behaviour, followed
// by a randomized run with an emulated TX engine. Honours TX_RETRY_EN.
// -----------------------------------------------------------------------------
module tb_usb_tx_arbiter;

  localparam int GAP_CYCLES    = 16;
  localparam int START_TIMEOUT = 64;
  localparam int BUF_DEPTH     = 64;
`ifdef TX_RETRY_EN
  localparam int ATTEMPTS = 4;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       hs_req = 1'b0, hs_type = 1'b0, data_req = 1'b0, tx_busy = 1'b0;
  logic [6:0] data_size = '0, buffer_occupancy = '0;
  logic       hs_grant, data_grant, tx_done, tx_error, arb_busy;
  logic [1:0] tx_packet;
  logic [6:0] tx_packet_data_size;

  usb_tx_arbiter #(
    .GAP_CYCLES(GAP_CYCLES), .START_TIMEOUT(START_TIMEOUT), .BUF_DEPTH(BUF_DEPTH)
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .hs_req(hs_req), .hs_type(hs_type), .hs_grant(hs_grant),
    .data_req(data_req), .data_size(data_size), .data_grant(data_grant),
    .buffer_occupancy(buffer_occupancy), .tx_busy(tx_busy),
    .tx_packet(tx_packet), .tx_packet_data_size(tx_packet_data_size),
    .tx_done(tx_done), .tx_error(tx_error), .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phases of a packet's life, timed by edge stamps rather than counters.
  localparam int M_IDLE = 0, M_ISSUED = 1, M_AWAIT = 2, M_ONAIR = 3, M_GAP = 4;
  int         m_phase = M_IDLE;
  int         m_stamp = 0;
  int         m_tries = 0;
  int         n_edge  = 0;
  logic       m_early = 1'b0;
  logic [1:0] m_cmd   = 2'b00;
  logic       e_hs_grant = 0, e_data_grant = 0, e_done = 0, e_err = 0, e_busy = 0;
  logic [1:0] e_pkt  = 2'b00;
  logic [6:0] e_size = '0;

  task automatic model_reset();
    m_phase = M_IDLE; m_early = 1'b0; m_cmd = 2'b00;
    e_hs_grant = 0; e_data_grant = 0; e_done = 0; e_err = 0; e_busy = 0;
    e_pkt = 2'b00; e_size = '0;
  endtask

  task automatic model_step();
    n_edge++;
    if (!n_rst) begin
      model_reset();
      return;
    end
    e_hs_grant = 0; e_data_grant = 0; e_done = 0; e_err = 0; e_pkt = 2'b00;
    case (m_phase)
      M_IDLE: begin
        if (hs_req) begin
          e_hs_grant = 1; m_cmd = hs_type ? 2'b11 : 2'b10;
          e_pkt = m_cmd; e_size = 0;
          m_phase = M_ISSUED; m_stamp = n_edge; m_tries = 1;
        end else if (data_req && int'(data_size) <= BUF_DEPTH
                     && int'(buffer_occupancy) >= int'(data_size)) begin
          e_data_grant = 1; m_cmd = 2'b01;
          e_pkt = m_cmd; e_size = data_size;
          m_phase = M_ISSUED; m_stamp = n_edge; m_tries = 1;
        end
      end
      M_ISSUED: begin
        m_early = tx_busy;
        m_phase = M_AWAIT;
      end
      M_AWAIT: begin
        if (tx_busy || m_early) m_phase = M_ONAIR;
        else if (n_edge - m_stamp == START_TIMEOUT) begin
          if (m_tries < ATTEMPTS) begin
            m_tries++; e_pkt = m_cmd; m_phase = M_ISSUED; m_stamp = n_edge;
          end else begin
            e_err = 1; m_phase = M_IDLE;
          end
        end
      end
      M_ONAIR: begin
        if (!tx_busy) begin
          e_done = 1; m_phase = M_GAP; m_stamp = n_edge;
        end
      end
      default: begin
        if (n_edge - m_stamp == GAP_CYCLES) m_phase = M_IDLE;
      end
    endcase
    e_busy = (m_phase != M_IDLE);
  endtask

  // ---------------- engine emulation ----------------
  bit eng_auto = 0;
  bit eng_sure = 1;
  int eng_wait = -1;
  int eng_len  = 0;

  task automatic engine_update();
    if (!eng_auto) return;
    if (tx_busy) begin
      eng_len--;
      if (eng_len <= 0) tx_busy = 1'b0;
    end else begin
      if (e_pkt != 2'b00) begin
        eng_wait = (!eng_sure && $urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 3));
        eng_len  = int'($urandom_range(1, 8));
      end
      if (eng_wait == 0) begin
        tx_busy = 1'b1; eng_wait = -1;
      end else if (eng_wait > 0) begin
        eng_wait--;
      end
    end
  endtask

  // One clock: model follows the edge, outputs are compared mid-cycle.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("hs_grant",   hs_grant,            e_hs_grant);
    check("data_grant", data_grant,          e_data_grant);
    check("tx_packet",  tx_packet,           e_pkt);
    check("pkt_size",   tx_packet_data_size, e_size);
    check("tx_done",    tx_done,             e_done);
    check("tx_error",   tx_error,            e_err);
    check("arb_busy",   arb_busy,            e_busy);
    engine_update();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Cycles until a condition shows, bounded.
  task automatic wait_hs_grant(input int lim, output int lat);
    lat = 0;
    do begin cycle(); lat++; end while (!hs_grant && lat < lim);
  endtask

  task automatic wait_data_grant(input int lim, output int lat);
    lat = 0;
    do begin cycle(); lat++; end while (!data_grant && lat < lim);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, cnt, reissue, dwait;

    // Reset then idle.
    model_reset();
    run(3);
    n_rst = 1'b1;
    run(20);

    // ACK path with a 30-cycle packet and the full gap.
    hs_req = 1'b1; hs_type = 1'b0;
    wait_hs_grant(10, lat);
    check("ack_latency", lat, 1);
    check("ack_code", tx_packet, 2'b10);
    hs_req = 1'b0;
    run(1);
    tx_busy = 1'b1;
    run(30);
    tx_busy = 1'b0;
    cnt = 0;
    do begin cycle(); cnt++; end while (!tx_done && cnt < 5);
    check("done_seen", tx_done, 1);
    cnt = 0;
    while (arb_busy && cnt < 40) begin cycle(); cnt++; end
    check("gap_len", cnt, GAP_CYCLES);

    // Priority: handshake first, DATA after the gap.
    eng_auto = 1; eng_sure = 1;
    hs_req = 1'b1; hs_type = 1'b1;
    data_req = 1'b1; data_size = 7'd8; buffer_occupancy = 7'd8;
    cycle();
    check("prio_hs_grant", hs_grant, 1);
    check("prio_nak_code", tx_packet, 2'b11);
    hs_req = 1'b0;
    wait_data_grant(200, lat);
    check("prio_data_grant", data_grant, 1);
    check("data_code", tx_packet, 2'b01);
    check("data_size8", tx_packet_data_size, 8);
    data_req = 1'b0;
    run(40);

    // Occupancy gating, then zero-length packet.
    data_req = 1'b1; data_size = 7'd20; buffer_occupancy = 7'd19;
    run(10);
    buffer_occupancy = 7'd20;
    wait_data_grant(10, lat);
    check("occ_latency", lat, 1);
    data_req = 1'b0;
    run(40);
    data_req = 1'b1; data_size = 7'd0; buffer_occupancy = 7'd0;
    wait_data_grant(10, lat);
    check("zlp_latency", lat, 1);
    check("zlp_size", tx_packet_data_size, 0);
    data_req = 1'b0;
    run(40);

    // Oversize request never granted; a later handshake still goes through.
    data_req = 1'b1; data_size = 7'd65; buffer_occupancy = 7'd100;
    run(8);
    hs_req = 1'b1; hs_type = 1'b0;
    wait_hs_grant(5, lat);
    check("hs_past_oversize", lat, 1);
    hs_req = 1'b0; data_req = 1'b0;
    run(40);

    // Start timeout: engine never starts.
    eng_auto = 0; tx_busy = 1'b0;
    hs_req = 1'b1; hs_type = 1'b0;
    wait_hs_grant(5, lat);
    hs_req = 1'b0;
    cnt = 0; reissue = 0;
    do begin
      cycle(); cnt++;
      if (tx_packet != 2'b00) reissue++;
    end while (!tx_error && cnt < 400);
    check("timeout_cycles", cnt, START_TIMEOUT * ATTEMPTS);
    check("reissues", reissue, ATTEMPTS - 1);
    cycle();
    check("no_gap_after_error", arb_busy, 0);
    run(3);

    // Reset mid-packet with a handshake pending.
    hs_req = 1'b1; hs_type = 1'b1;
    wait_hs_grant(5, lat);
    tx_busy = 1'b1;
    run(5);
    #2 n_rst = 1'b0;
    #1;
    check("rst_arb_busy", arb_busy, 0);
    check("rst_tx_packet", tx_packet, 0);
    check("rst_size", tx_packet_data_size, 0);
    check("rst_grants", {hs_grant, data_grant, tx_done, tx_error}, 0);
    model_reset();
    tx_busy = 1'b0;
    cycle();
    n_rst = 1'b1;
    wait_hs_grant(5, lat);
    check("post_rst_grant", lat, 1);
    check("post_rst_code", tx_packet, 2'b11);
    hs_req = 1'b0;
    run(40);

    // Randomized traffic with an emulated engine that occasionally stalls.
    eng_auto = 1; eng_sure = 0; dwait = 0;
    for (int i = 0; i < 3000; i++) begin
      cycle();
      if (e_hs_grant) hs_req = 1'b0;
      if (e_data_grant) data_req = 1'b0;
      if (!hs_req && $urandom_range(0, 24) == 0) begin
        hs_req = 1'b1; hs_type = 1'($urandom_range(0, 1));
      end
      if (!data_req && $urandom_range(0, 9) == 0) begin
        data_req = 1'b1; dwait = 0;
        data_size = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(65, 80))
                                                : 7'($urandom_range(0, 64));
      end else if (data_req) begin
        dwait++;
        if (dwait > 60) data_req = 1'b0;
      end
      buffer_occupancy = 7'($urandom_range(0, 70));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
